// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        GRANT
    } state_e;

    // Index width for n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface rr_grant_scheduler_if #(
    parameter int unsigned N_REQ = 3
);
    localparam int unsigned IW = arb_pkg::idx_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    logic             busy;
    logic             preempt;

    modport master (output req, input gnt, gnt_id, busy, preempt);
    modport slave  (input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    pick,
    output logic             any
);
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    assign any = |req;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end
endmodule

// File: rtl/rr_grant_scheduler.sv
// Blocking round-robin grant scheduler (IDLE -> ARB -> GRANT Moore machine).
// Optional hold-time preemption is enabled by defining ARB_PREEMPT_EN.
module rr_grant_scheduler
    import arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rr_grant_scheduler_if.slave  bus
);
    localparam int unsigned IW = idx_w(N_REQ);

    if (N_REQ < 2 || HOLD_MAX < 1) begin : g_bad_params
        $error("rr_grant_scheduler: N_REQ must be >= 2 and HOLD_MAX >= 1");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gnt_id_q, gnt_id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             preempt_q, preempt_d;
    logic [IW-1:0]    pick;
    logic             any;
    logic             hold_expired;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

`ifdef ARB_PREEMPT_EN
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Zero in every non-GRANT cycle, so a fresh grant always starts from 0.
    always_comb begin
        cnt_d = (state_q == GRANT) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hold_expired = (cnt_q == CW'(HOLD_MAX - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) state_d = ARB;
            end
            ARB: begin
                if (any) begin
                    state_d  = GRANT;
                    gnt_d    = N_REQ'(1) << pick;
                    gnt_id_d = pick;
                    ptr_d    = (pick == IW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // A release on the last allowed cycle wins over preemption.
                if (!bus.req[gnt_id_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (hold_expired) begin
                    state_d   = ARB;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    preempt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler with a cycle-level reference model.
module tb_rr_grant_scheduler;
    localparam int N  = 3;
    localparam int HM = 15;
`ifdef ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: phase 0 = waiting, 1 = arbitrating, 2 = owner holds grant.
    int m_phase, m_owner, m_ptr, m_held;
    bit m_pre;

    rr_grant_scheduler_if #(.N_REQ(N)) bus ();

    rr_grant_scheduler #(
        .N_REQ    (N),
        .HOLD_MAX (HM)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic m_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_pre = 1'b0;
    endtask

    task automatic m_step(input logic [2:0] r);
        int c;
        m_pre = 1'b0;
        case (m_phase)
            0: if (r != 3'b000) m_phase = 1;
            1: begin
                if (r == 3'b000) begin
                    m_phase = 0;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (r[c[1:0]]) begin
                            m_owner = c;
                            break;
                        end
                    end
                    m_ptr   = (m_owner + 1) % N;
                    m_held  = 1;
                    m_phase = 2;
                end
            end
            default: begin
                if (!r[m_owner[1:0]]) begin
                    m_phase = 0;
                end else if (PRE && m_held == HM) begin
                    m_phase = 1;
                    m_pre   = 1'b1;
                end else begin
                    m_held++;
                end
            end
        endcase
    endtask

    // Drive one cycle of req, advance the model, then compare just after the edge.
    task automatic cycle(input logic [2:0] r, input string tag);
        logic [2:0] eg;
        logic [1:0] eid;
        logic       eb, ep;
        bus.req = r;
        m_step(r);
        @(posedge clk);
        #1;
        eg  = (m_phase == 2) ? (3'b001 << m_owner) : 3'b000;
        eid = m_owner[1:0];
        eb  = (m_phase == 2);
        ep  = m_pre;
        n_checks++;
        if ({bus.gnt, bus.gnt_id, bus.busy, bus.preempt} !== {eg, eid, eb, ep}) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b preempt=%b, want gnt=%b id=%0d busy=%b preempt=%b",
                     tag, bus.gnt, bus.gnt_id, bus.busy, bus.preempt, eg, eid, eb, ep);
        end
        n_checks++;
        if ($countones(bus.gnt) > 1) begin
            n_fail++;
            $display("FAIL %s_onehot: got gnt=%b, want at most one bit", tag, bus.gnt);
        end
    endtask

    task automatic do_reset();
        bus.req = 3'b000;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
    endtask

    task automatic test_reset();
        bus.req = 3'b000;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.gnt, bus.gnt_id, bus.busy, bus.preempt} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b id=%0d busy=%b preempt=%b, want all zero",
                     bus.gnt, bus.gnt_id, bus.busy, bus.preempt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
    endtask

    task automatic test_single();
        logic [2:0] r;
        for (int c = 0; c < 10; c++) begin
            r = (c < 6) ? 3'b100 : 3'b000;
            cycle(r, "single");
            if (c == 0 || c >= 6) begin
                n_checks++;
                if (bus.gnt !== 3'b000) begin
                    n_fail++;
                    $display("FAIL single_low c=%0d: got gnt=%b, want 000", c + 1, bus.gnt);
                end
            end else begin
                n_checks++;
                if (bus.gnt !== 3'b100 || bus.gnt_id !== 2'd2) begin
                    n_fail++;
                    $display("FAIL single_grant c=%0d: got gnt=%b id=%0d, want gnt=100 id=2",
                             c + 1, bus.gnt, bus.gnt_id);
                end
            end
        end
    endtask

    task automatic test_rotation();
        int         order[$];
        int         want[4] = '{0, 1, 2, 0};
        logic [2:0] r;
        logic [2:0] prev;
        prev = bus.gnt;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            r = 3'b111;
            if (m_phase == 2 && m_held >= 4) r[m_owner[1:0]] = 1'b0;
            cycle(r, "rotation");
            if (bus.gnt !== 3'b000 && prev === 3'b000) order.push_back(int'(bus.gnt_id));
            prev = bus.gnt;
        end
        n_checks++;
        if (order.size() != 4) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d grants, want 4", order.size());
        end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            n_checks++;
            if (order[i] != want[i]) begin
                n_fail++;
                $display("FAIL rotation_order[%0d]: got %0d, want %0d", i, order[i], want[i]);
            end
        end
        repeat (3) cycle(3'b000, "rotation_drain");
    endtask

    task automatic test_withdraw();
        cycle(3'b010, "withdraw");
        for (int c = 0; c < 4; c++) begin
            cycle(3'b000, "withdraw");
            n_checks++;
            if (bus.gnt !== 3'b000) begin
                n_fail++;
                $display("FAIL withdraw_nogrant: got gnt=%b, want 000", bus.gnt);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (4) cycle(3'b100, "async_pre");
        bus.req = 3'b000;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got gnt=%b busy=%b id=%0d, want 000/0/0",
                     bus.gnt, bus.busy, bus.gnt_id);
        end
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cycle(3'b011, "after_reset");
        n_checks++;
        if (bus.gnt !== 3'b001) begin
            n_fail++;
            $display("FAIL after_reset_ptr: got gnt=%b, want 001", bus.gnt);
        end
        repeat (3) cycle(3'b000, "after_reset_drain");
    endtask

    task automatic test_random();
        logic [2:0] r;
        r = 3'b000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            cycle(r, "random");
        end
        repeat (3) cycle(3'b000, "random_drain");
    endtask

    // Expected pattern from a fixed request: ARB at i=0, then 15 grant / 1 preempt cycles.
    task automatic test_hold(input logic [2:0] r, input string tag);
        logic [2:0] eg;
        logic       ep;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            cycle(r, tag);
            if (!PRE) begin
                eg = (i == 0) ? 3'b000 : 3'b001;
                ep = 1'b0;
            end else if (i == 0 || i == 16 || i == 32) begin
                eg = 3'b000;
                ep = (i != 0);
            end else begin
                ep = 1'b0;
                eg = (r == 3'b011 && i > 16 && i < 32) ? 3'b010 : 3'b001;
            end
            n_checks++;
            if (bus.gnt !== eg || bus.preempt !== ep) begin
                n_fail++;
                $display("FAIL %s_pattern i=%0d: got gnt=%b preempt=%b, want gnt=%b preempt=%b",
                         tag, i, bus.gnt, bus.preempt, eg, ep);
            end
        end
        repeat (3) cycle(3'b000, "hold_drain");
    endtask

    initial begin
        bus.req = 3'b000;
        m_reset();
        test_reset();
        test_single();
        test_rotation();
        test_withdraw();
        test_async_reset();
        test_random();
`ifdef ARB_PREEMPT_EN
        test_hold(3'b011, "preempt");
`endif
        test_hold(3'b001, "lone");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
